// File: rtl/sm83_irq_ctl_if.sv
// Core-side bus between the sm83 core and its interrupt controller:
// memory-mapped register access plus the irq/iack vectors.
interface sm83_irq_ctl_if #(
    parameter int WORD_SIZE = 8,
    parameter int ADR_WIDTH = 16
);
    logic [ADR_WIDTH-1:0] adr;
    logic [WORD_SIZE-1:0] din;
    logic [WORD_SIZE-1:0] dout;
    logic                 dout_oe;
    logic                 p_rd;
    logic                 p_wr;
    logic [WORD_SIZE-1:0] irq;
    logic [WORD_SIZE-1:0] iack;
    logic                 int_pending;

    // Core side: drives the bus and acknowledges interrupts.
    modport master (
        output adr, din, p_rd, p_wr, iack,
        input  dout, dout_oe, irq, int_pending
    );

    // Controller side: serves register accesses and raises interrupts.
    modport slave (
        input  adr, din, p_rd, p_wr, iack,
        output dout, dout_oe, irq, int_pending
    );
endinterface

// File: rtl/sm83_irq_ctl.sv
// sm83 interrupt controller: holds IF/IE, edge-detects peripheral
// request lines, clears flags on acknowledge and presents a registered
// pending-and-enabled vector to the core.
module sm83_irq_ctl #(
    parameter int                  NUM_SRC   = 5,
    parameter int                  WORD_SIZE = 8,
    parameter int                  ADR_WIDTH = 16,
    parameter logic [ADR_WIDTH-1:0] IF_ADR   = 16'hff0f,
    parameter logic [ADR_WIDTH-1:0] IE_ADR   = 16'hffff
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [NUM_SRC-1:0] src_req,
    sm83_irq_ctl_if.slave      bus
);

    logic [NUM_SRC-1:0]   req_q, req_d;
    logic [NUM_SRC-1:0]   if_q, if_d;
    logic [WORD_SIZE-1:0] ie_q, ie_d;
    logic [WORD_SIZE-1:0] irq_q, irq_d;
    logic [NUM_SRC-1:0]   rise;
    logic                 wr_if;
    logic                 wr_ie;
    logic [WORD_SIZE-1:0] if_read;

    // Next-state: rising request wins over acknowledge, which wins over CPU write.
    always_comb begin
        wr_if = bus.p_wr && (bus.adr == IF_ADR);
        wr_ie = bus.p_wr && (bus.adr == IE_ADR);
        rise  = src_req & ~req_q;
        req_d = src_req;
        if_d  = ((wr_if ? bus.din[NUM_SRC-1:0] : if_q) & ~bus.iack[NUM_SRC-1:0]) | rise;
        ie_d  = wr_ie ? bus.din : ie_q;
        irq_d = '0;
        irq_d[NUM_SRC-1:0] = if_d & ie_d[NUM_SRC-1:0];
    end

    // State registers; req_q resets high so a line held across reset does not fire.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            req_q <= '1;
            if_q  <= '0;
            ie_q  <= '0;
            irq_q <= '0;
        end else begin
            req_q <= req_d;
            if_q  <= if_d;
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    // Register readback; unimplemented IF bits read as one.
    always_comb begin
        if_read = '1;
        if_read[NUM_SRC-1:0] = if_q;
        bus.dout    = 'x;
        bus.dout_oe = 1'b0;
        if (bus.p_rd && (bus.adr == IF_ADR)) begin
            bus.dout    = if_read;
            bus.dout_oe = 1'b1;
        end else if (bus.p_rd && (bus.adr == IE_ADR)) begin
            bus.dout    = ie_q;
            bus.dout_oe = 1'b1;
        end
    end

    assign bus.irq         = irq_q;
    assign bus.int_pending = |irq_q;

    // The two registers must decode to distinct addresses.
    adr_distinct_a: assert property (@(posedge clk) IF_ADR != IE_ADR);

    // The core acknowledges at most one interrupt per cycle.
    iack_onehot0_a: assert property (@(posedge clk) disable iff (!n_reset) $onehot0(bus.iack));

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Self-checking bench for sm83_irq_ctl: directed scenarios followed by
// randomized traffic, all compared against a per-bit behavioural model.
module tb_sm83_irq_ctl;

    localparam logic [15:0] IF_ADR = 16'hff0f;
    localparam logic [15:0] IE_ADR = 16'hffff;

    logic       clk;
    logic       n_reset;
    logic [4:0] src_req;

    int passed;
    int total;

    // Reference model state: flags, enables, expected irq, last sampled requests.
    logic [4:0] m_if;
    logic [7:0] m_ie;
    logic [7:0] m_irq;
    logic [4:0] m_prev;

    sm83_irq_ctl_if #(.WORD_SIZE(8), .ADR_WIDTH(16)) bus ();

    sm83_irq_ctl #(
        .NUM_SRC(5), .WORD_SIZE(8), .ADR_WIDTH(16),
        .IF_ADR(IF_ADR), .IE_ADR(IE_ADR)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .src_req (src_req),
        .bus     (bus)
    );

    // Free-running core clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        else
            passed++;
    endtask

    // Model reaction to reset: everything cleared, request history all ones.
    task automatic modelReset();
        m_if   = '0;
        m_ie   = '0;
        m_irq  = '0;
        m_prev = '1;
    endtask

    // Drive one cycle of bus traffic, check readback before the edge,
    // advance the model across the edge and check irq after it.
    task automatic applyStimulus(input logic [4:0] req, input logic wr, input logic rd,
                                 input logic [15:0] a, input logic [7:0] d, input logic [7:0] ack);
        logic [4:0] nxt_if;
        logic [7:0] nxt_ie;
        logic       hit;
        src_req      = req;
        bus.p_wr     = wr;
        bus.p_rd     = rd;
        bus.adr      = a;
        bus.din      = d;
        bus.iack     = ack;
        #1;
        hit = rd && (a == IF_ADR || a == IE_ADR);
        checkOutput("dout_oe", {31'd0, bus.dout_oe}, {31'd0, hit});
        if (hit && a == IF_ADR)
            checkOutput("if_read", {24'd0, bus.dout}, {24'd0, 3'b111, m_if});
        else if (hit)
            checkOutput("ie_read", {24'd0, bus.dout}, {24'd0, m_ie});
        for (int i = 0; i < 5; i++) begin
            if (req[i] && !m_prev[i])
                nxt_if[i] = 1'b1;
            else if (ack[i])
                nxt_if[i] = 1'b0;
            else if (wr && a == IF_ADR)
                nxt_if[i] = d[i];
            else
                nxt_if[i] = m_if[i];
        end
        nxt_ie = (wr && a == IE_ADR) ? d : m_ie;
        @(posedge clk);
        #1;
        m_if   = nxt_if;
        m_ie   = nxt_ie;
        m_prev = req;
        m_irq  = {3'b000, nxt_if & nxt_ie[4:0]};
        checkOutput("irq", {24'd0, bus.irq}, {24'd0, m_irq});
        checkOutput("int_pending", {31'd0, bus.int_pending}, {31'd0, m_irq != 8'h00});
    endtask

    // Directed scenarios, randomized traffic, then an asynchronous mid-run reset.
    initial begin
        logic [15:0] a;
        logic [7:0]  ack;
        passed   = 0;
        total    = 0;
        n_reset  = 1'b0;
        src_req  = 5'b00100;
        bus.adr  = '0;
        bus.din  = '0;
        bus.p_rd = 1'b0;
        bus.p_wr = 1'b0;
        bus.iack = '0;
        modelReset();
        #12;
        checkOutput("reset_irq", {24'd0, bus.irq}, 32'h0);
        checkOutput("reset_pending", {31'd0, bus.int_pending}, 32'h0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;

        // Request held through reset release must not fire; then re-raise it.
        applyStimulus(5'b00100, 0, 1, IF_ADR, 8'h00, 8'h00);
        applyStimulus(5'b00100, 0, 1, IE_ADR, 8'h00, 8'h00);
        applyStimulus(5'b00100, 0, 1, IF_ADR, 8'h00, 8'h00);
        applyStimulus(5'b00000, 0, 0, IF_ADR, 8'h00, 8'h00);
        applyStimulus(5'b00100, 0, 0, IF_ADR, 8'h00, 8'h00);
        applyStimulus(5'b00100, 0, 1, IF_ADR, 8'h00, 8'h04);
        applyStimulus(5'b00000, 0, 1, IF_ADR, 8'h00, 8'h00);

        // Basic request on source 0 with IE=01.
        applyStimulus(5'b00000, 1, 0, IE_ADR, 8'h01, 8'h00);
        applyStimulus(5'b00001, 0, 0, IF_ADR, 8'h00, 8'h00);
        applyStimulus(5'b00000, 0, 1, IF_ADR, 8'h00, 8'h00);

        // New rise on the same edge as its acknowledge keeps the flag.
        applyStimulus(5'b00001, 0, 1, IF_ADR, 8'h00, 8'h01);
        applyStimulus(5'b00001, 0, 1, IF_ADR, 8'h00, 8'h00);

        // Rise beats a CPU write of zero on the same edge.
        applyStimulus(5'b00001, 1, 0, IE_ADR, 8'h04, 8'h00);
        applyStimulus(5'b00001, 1, 0, IF_ADR, 8'h1f, 8'h00);
        applyStimulus(5'b00010, 1, 1, IF_ADR, 8'h00, 8'h00);
        applyStimulus(5'b00010, 0, 1, IF_ADR, 8'h00, 8'h00);

        // Acknowledge clears; acknowledge of an unimplemented bit does nothing.
        applyStimulus(5'b00010, 1, 0, IF_ADR, 8'h04, 8'h00);
        applyStimulus(5'b00010, 0, 1, IF_ADR, 8'h00, 8'h04);
        applyStimulus(5'b00010, 1, 0, IF_ADR, 8'h04, 8'h00);
        applyStimulus(5'b00010, 0, 1, IF_ADR, 8'h00, 8'h80);
        applyStimulus(5'b00010, 0, 1, IE_ADR, 8'h00, 8'h00);

        // Randomized traffic with onehot0 acknowledges.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(2, 0))
                0:       a = IF_ADR;
                1:       a = IE_ADR;
                default: a = 16'($urandom) & 16'hff00;
            endcase
            ack = ($urandom_range(1, 0) == 1) ? 8'(1 << $urandom_range(7, 0)) : 8'h00;
            applyStimulus(5'($urandom), ($urandom_range(3, 0) == 0), 1'($urandom),
                          a, 8'($urandom), ack);
        end

        // Asynchronous reset between edges clears state without a clock.
        applyStimulus(5'b11111, 1, 0, IE_ADR, 8'hff, 8'h00);
        applyStimulus(5'b00000, 0, 0, IF_ADR, 8'h00, 8'h00);
        applyStimulus(5'b11111, 0, 0, IF_ADR, 8'h00, 8'h00);
        checkOutput("pre_reset_irq", {24'd0, bus.irq}, 32'h1f);
        n_reset = 1'b0;
        modelReset();
        #2;
        checkOutput("async_reset_irq", {24'd0, bus.irq}, 32'h0);
        checkOutput("async_reset_pending", {31'd0, bus.int_pending}, 32'h0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        applyStimulus(5'b11111, 0, 1, IF_ADR, 8'h00, 8'h00);
        applyStimulus(5'b11111, 0, 1, IE_ADR, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
